// File: rtl/sar_channel_scheduler_pkg.sv
// sar_sched_pkg: shared types and constants for the SAR channel scheduler.
//   sched_state_e : scheduler FSM states
//   DEF_*         : default build parameters
//   ch_w()        : width of a channel index, at least 1 bit
package sar_sched_pkg;

    localparam int unsigned DEF_N_CH          = 4;
    localparam int unsigned DEF_N_BITS        = 4;
    localparam int unsigned DEF_SETTLE_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        CONVERT,
        HOLD
    } sched_state_e;

    function automatic int unsigned ch_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sar_channel_scheduler_if.sv
// sar_channel_scheduler_if: result handshake between the scheduler and its
// consumer.
//   RES_VALID  result available (driven by master)
//   RES_READY  consumer accepts result (driven by slave)
//   RES_DATA   N_BITS conversion result
//   RES_CH     channel tag of RES_DATA
interface sar_channel_scheduler_if #(
    parameter int unsigned N_CH   = sar_sched_pkg::DEF_N_CH,
    parameter int unsigned N_BITS = sar_sched_pkg::DEF_N_BITS
) ();

    localparam int unsigned CW = sar_sched_pkg::ch_w(N_CH);

    logic              RES_VALID;
    logic              RES_READY;
    logic [N_BITS-1:0] RES_DATA;
    logic [CW-1:0]     RES_CH;

    modport master (
        output RES_VALID,
        output RES_DATA,
        output RES_CH,
        input  RES_READY
    );

    modport slave (
        input  RES_VALID,
        input  RES_DATA,
        input  RES_CH,
        output RES_READY
    );

endinterface

// File: rtl/sar_channel_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   REQ    in   N_CH  request vector
//   PTR    in   CW    highest-priority channel this round
//   GRANT  out  N_CH  one-hot winner (0 when no request)
//   IDX    out  CW    index of winner (0 when no request)
//   ANY    out  1     at least one request present
module rr_arbiter
    import sar_sched_pkg::*;
#(
    parameter int unsigned N_CH = DEF_N_CH
) (
    input  logic [N_CH-1:0]       REQ,
    input  logic [ch_w(N_CH)-1:0] PTR,
    output logic [N_CH-1:0]       GRANT,
    output logic [ch_w(N_CH)-1:0] IDX,
    output logic                  ANY
);

    localparam int unsigned CW = ch_w(N_CH);

    int unsigned c;

    // Scan channels starting at PTR and wrapping; the first set bit wins.
    always_comb begin
        GRANT = '0;
        IDX   = '0;
        ANY   = 1'b0;
        c     = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            c = (32'(PTR) + k) % N_CH;
            if (!ANY && REQ[CW'(c)]) begin
                ANY            = 1'b1;
                IDX            = CW'(c);
                GRANT[CW'(c)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sar_channel_scheduler.sv
// sar_channel_scheduler: time-shares one SAR ADC core across N_CH channels.
//   CLK, RESET  clock and synchronous active-high reset
//   REQ/GRANT   per-channel level request, one-cycle one-hot grant pulse
//   MUX_SEL     analog mux select, follows the latest grant
//   SAR_RESET   1 = cap DAC reset/track, 0 = converting/holding
//   DAC_CODE    trial code to the cap DAC; VCOMP comparator feedback
//   BUSY        high whenever the FSM is not idle
//   res         result handshake (RES_VALID/READY/DATA/CH)
// All outputs come straight from registers.
module sar_channel_scheduler
    import sar_sched_pkg::*;
#(
    parameter int unsigned N_CH          = DEF_N_CH,
    parameter int unsigned N_BITS        = DEF_N_BITS,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [N_CH-1:0]           REQ,
    output logic [N_CH-1:0]           GRANT,
    output logic [ch_w(N_CH)-1:0]     MUX_SEL,
    output logic                      SAR_RESET,
    output logic [N_BITS-1:0]         DAC_CODE,
    input  logic                      VCOMP,
    output logic                      BUSY,
    sar_channel_scheduler_if.master   res
);

    localparam int unsigned CW          = ch_w(N_CH);
    localparam int unsigned SW          = ch_w(SETTLE_CYCLES);
    localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam logic [N_BITS-1:0] MSB_MASK = N_BITS'(1) << (N_BITS - 1);

    sched_state_e      state_q, state_n;
    logic [SW-1:0]     cnt_q, cnt_n;
    logic [N_BITS-1:0] mask_q, mask_n;
    logic [N_BITS-1:0] work_q, work_n;
    logic [CW-1:0]     ptr_q, ptr_n;
    logic [N_CH-1:0]   grant_q, grant_n;
    logic [CW-1:0]     mux_q, mux_n;
    logic              sar_rst_q, sar_rst_n;
    logic [N_BITS-1:0] dac_q, dac_n;
    logic              busy_q, busy_n;
    logic              valid_q, valid_n;
    logic [N_BITS-1:0] data_q, data_n;
    logic [CW-1:0]     rch_q, rch_n;

    logic [N_CH-1:0]   arb_grant;
    logic [CW-1:0]     arb_idx;
    logic              arb_any;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .REQ   (REQ),
        .PTR   (ptr_q),
        .GRANT (arb_grant),
        .IDX   (arb_idx),
        .ANY   (arb_any)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mask_q    <= '0;
            work_q    <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            mux_q     <= '0;
            sar_rst_q <= 1'b1;
            dac_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            rch_q     <= '0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            mask_q    <= mask_n;
            work_q    <= work_n;
            ptr_q     <= ptr_n;
            grant_q   <= grant_n;
            mux_q     <= mux_n;
            sar_rst_q <= sar_rst_n;
            dac_q     <= dac_n;
            busy_q    <= busy_n;
            valid_q   <= valid_n;
            data_q    <= data_n;
            rch_q     <= rch_n;
        end
    end

    // Registered outputs are computed from the next state so they line up
    // with the state they describe.  mask_q is the one-hot bit under trial.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        mask_n  = mask_q;
        work_n  = work_q;
        ptr_n   = ptr_q;
        grant_n = '0;
        mux_n   = mux_q;
        dac_n   = dac_q;
        valid_n = valid_q;
        data_n  = data_q;
        rch_n   = rch_q;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_n = arb_grant;
                    mux_n   = arb_idx;
                    ptr_n   = (arb_idx == CW'(N_CH - 1)) ? '0 : arb_idx + CW'(1);
                    if (SETTLE_CYCLES == 0) begin
                        state_n = SAMPLE;
                        dac_n   = '0;
                        work_n  = '0;
                    end else begin
                        state_n = SETTLE;
                        cnt_n   = SW'(SETTLE_LAST);
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_n = SAMPLE;
                    dac_n   = '0;
                    work_n  = '0;
                end else begin
                    cnt_n = cnt_q - SW'(1);
                end
            end
            SAMPLE: begin
                state_n = CONVERT;
                mask_n  = MSB_MASK;
                dac_n   = MSB_MASK;
            end
            CONVERT: begin
                work_n = VCOMP ? (work_q | mask_q) : work_q;
                mask_n = mask_q >> 1;
                if (mask_q[0]) begin
                    state_n = HOLD;
                    dac_n   = work_n;
                    valid_n = 1'b1;
                    data_n  = work_n;
                    rch_n   = mux_q;
                end else begin
                    dac_n = work_n | (mask_q >> 1);
                end
            end
            HOLD: begin
                if (res.RES_READY) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        sar_rst_n = !((state_n == CONVERT) || (state_n == HOLD));
        busy_n    = (state_n != IDLE);
    end

    assign GRANT         = grant_q;
    assign MUX_SEL       = mux_q;
    assign SAR_RESET     = sar_rst_q;
    assign DAC_CODE      = dac_q;
    assign BUSY          = busy_q;
    assign res.RES_VALID = valid_q;
    assign res.RES_DATA  = data_q;
    assign res.RES_CH    = rch_q;

endmodule
